// File: rtl/sw_seq_loader_pkg.sv
// Shared constants and state encoding for the Smith-Waterman sequence loader.
package sw_pkg;

  localparam int unsigned RX_BASE     = 0;
  localparam int unsigned TX_BASE     = 4;
  localparam int unsigned STATUS_BASE = 8;
  localparam int unsigned TX_OK_BIT   = 6;
  localparam int unsigned RX_OK_BIT   = 7;

  localparam int unsigned REF_LENGTH  = 128;
  localparam int unsigned READ_LENGTH = 128;
  localparam int unsigned REF_BYTES   = REF_LENGTH / 4;
  localparam int unsigned READ_BYTES  = READ_LENGTH / 4;

  typedef enum logic [1:0] {
    S_POLL,
    S_READ,
    S_HOLD
  } loader_state_t;

endpackage

// File: rtl/sw_seq_loader_if.sv
// Avalon-MM read-only master link between the loader and the UART register file.
interface sw_seq_loader_if #(
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/sw_seq_loader.sv
// Polls the UART, assembles a reference+read job frame and hands it to the
// Smith-Waterman core over valid/ready; partial frames are dropped on timeout.
module sw_seq_loader
  import sw_pkg::*;
#(
  parameter int unsigned REF_BYTES      = 32,
  parameter int unsigned READ_BYTES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned ADDR_W         = 5
) (
  input  logic                    avm_clk,
  input  logic                    avm_rst_n,
  sw_seq_loader_if.master         avm,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [8*REF_BYTES-1:0]  o_sequence_ref,
  output logic [8*READ_BYTES-1:0] o_sequence_read,
  output logic                    o_frame_err,
  output logic                    o_busy
);

  localparam int unsigned FRAME_BYTES = REF_BYTES + READ_BYTES;
  localparam int unsigned BUF_W       = 8 * FRAME_BYTES;
  localparam int unsigned CNT_W       = $clog2(FRAME_BYTES);
  localparam int unsigned IDLE_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] ADDR_RX     = ADDR_W'(RX_BASE);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(STATUS_BASE);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(FRAME_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic       rx_done;
  logic       rx_ok;
  logic [7:0] rx_byte;

  assign rx_done = read_q && !avm.avm_waitrequest;
  assign rx_byte = avm.avm_readdata[7:0];
  assign rx_ok   = avm.avm_readdata[RX_OK_BIT];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    read_d     = read_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    buf_d      = buf_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;

    unique case (state_q)
      S_POLL: begin
        if (rx_done && rx_ok) begin
          state_d    = S_READ;
          addr_d     = ADDR_RX;
          idle_cnt_d = '0;
        end else if (byte_cnt_q != '0) begin
          if (idle_cnt_q == IDLE_LAST) begin
            byte_cnt_d = '0;
            idle_cnt_d = '0;
            err_d      = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end

      S_READ: begin
        if (rx_done) begin
          buf_d = {buf_q[BUF_W-9:0], rx_byte};
          // The final byte leaves the count at its last value instead of
          // wrapping; the handshake clears it.
          if (byte_cnt_q == CNT_LAST) begin
            state_d = S_HOLD;
            read_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = S_POLL;
            addr_d     = ADDR_STATUS;
          end
        end
      end

      S_HOLD: begin
        if (valid_q && i_ready) begin
          valid_d    = 1'b0;
          byte_cnt_d = '0;
          state_d    = S_POLL;
          read_d     = 1'b1;
          addr_d     = ADDR_STATUS;
        end
      end

      default: begin
        state_d = S_POLL;
        read_d  = 1'b1;
        addr_d  = ADDR_STATUS;
      end
    endcase

    busy_d = (byte_cnt_d != '0) || valid_d;
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state_q    <= S_POLL;
      addr_q     <= ADDR_STATUS;
      read_q     <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      buf_q      <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      buf_q      <= buf_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign avm.avm_address = addr_q;
  assign avm.avm_read    = read_q;
  assign o_valid         = valid_q;
  assign o_frame_err     = err_q;
  assign o_busy          = busy_q;
  assign o_sequence_ref  = buf_q[BUF_W-1 -: 8*REF_BYTES];
  assign o_sequence_read = buf_q[8*READ_BYTES-1:0];

endmodule
